// File: rtl/weight_stream_loader_pkg.sv
// Shared definitions for the weight stream loader: network geometry, derived
// node/weight counts, address and node-index widths, the loader FSM state
// encoding and the words-per-node helper used by the address generator.
package weight_stream_loader_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int N_IN         = 2;
  localparam int N_H1         = 5;
  localparam int N_H2         = 5;
  localparam int N_OUT        = 3;
  localparam int TOTAL_NODE   = N_H1 + N_H2 + N_OUT;
  localparam int TOTAL_WEIGHT = N_H1 * (N_IN + 1) + N_H2 * (N_H1 + 1) + N_OUT * (N_H2 + 1);
  localparam int ADDR_W       = $clog2(TOTAL_WEIGHT);
  localparam int NODE_W       = $clog2(TOTAL_NODE);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STREAM    = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  // Words per node: fan-in of the node's layer plus one bias weight.
  function automatic logic [ADDR_W-1:0] wpn(input logic [NODE_W-1:0] node);
    logic [ADDR_W-1:0] n_s;
    if (node < NODE_W'(N_H1)) begin
      n_s = ADDR_W'(N_IN + 1);
    end else if (node < NODE_W'(N_H1 + N_H2)) begin
      n_s = ADDR_W'(N_H1 + 1);
    end else begin
      n_s = ADDR_W'(N_H2 + 1);
    end
    return n_s;
  endfunction

endpackage

// File: rtl/weight_stream_loader_addr_gen.sv
// weight_addr_gen: keeps the current node index and the RAM cursor for the
// weight stream loader.
//   clk, rst_n  clock / async active-low reset
//   clear       return cursor, node and word count to zero
//   step        one RAM read issued this cycle (advance cursor)
//   advance     move on to the next node (cursor keeps running)
//   mem_addr    RAM word address (the cursor)
//   node        current node index
//   last_word   the read at mem_addr is the current node's final word
module weight_addr_gen
  import weight_stream_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic              advance,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NODE_W-1:0] node,
  output logic              last_word
);

  logic [ADDR_W-1:0] cursor_r;
  logic [NODE_W-1:0] node_r;
  logic [ADDR_W-1:0] word_r;
  logic [ADDR_W-1:0] node_wpn_s;

  // Cursor walks the RAM contiguously; word_r counts reads inside the current node.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_r <= ADDR_W'(0);
      node_r   <= NODE_W'(0);
      word_r   <= ADDR_W'(0);
    end else if (clear) begin
      cursor_r <= ADDR_W'(0);
      node_r   <= NODE_W'(0);
      word_r   <= ADDR_W'(0);
    end else begin
      if (step) begin
        cursor_r <= cursor_r + ADDR_W'(1);
        word_r   <= word_r + ADDR_W'(1);
      end
      if (advance) begin
        node_r <= node_r + NODE_W'(1);
        word_r <= ADDR_W'(0);
      end
    end
  end

  assign node_wpn_s = wpn(node_r);
  assign mem_addr   = cursor_r;
  assign node       = node_r;
  assign last_word  = (word_r == node_wpn_s - ADDR_W'(1));

endmodule

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: reads every network weight from a synchronous weight
// RAM and streams it, node by node, onto the feed_forward weight-load port.
// A node is only left once its load-done flag is seen in WAIT_DONE.
//   i_start               one-cycle load request (ignored while busy)
//   o_busy / o_done       load in progress / one-cycle completion pulse
//   o_error               sticky watchdog error, cleared by i_start
//   o_mem_rd/o_mem_addr   RAM read strobe and word address
//   i_mem_data            RAM data, valid the cycle after o_mem_rd
//   o_load_weight_enable  o_weight carries a word this cycle
//   o_weight_addr         one-hot current node select
//   i_load_weight_done    per-node "all weights received" flags
// Optional feature macro WEIGHT_LOADER_TIMEOUT_EN: adds a WAIT_DONE watchdog
// of TIMEOUT_CYCLES cycles that aborts the load and raises o_error.
module weight_stream_loader
  import weight_stream_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_mem_rd,
  output logic [ADDR_W-1:0]     o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_load_weight_enable,
  output logic [TOTAL_NODE-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0] o_weight,
  input  logic [TOTAL_NODE-1:0] i_load_weight_done
);

  state_e                state_r;
  state_e                state_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  mem_rd_r;
  logic                  rd_d1_r;
  logic                  enable_r;
  logic [DATA_WIDTH-1:0] weight_r;
  logic [TOTAL_NODE-1:0] weight_addr_r;
  logic [NODE_W-1:0]     node_s;
  logic                  last_word_s;
  logic                  done_bit_s;
  logic                  start_s;
  logic                  clear_s;
  logic                  advance_s;

  assign start_s    = (state_r == ST_IDLE) && i_start;
  assign clear_s    = (state_r == ST_IDLE);
  assign done_bit_s = i_load_weight_done[node_s];
  assign advance_s  = (state_r == ST_NEXT) && (state_s == ST_STREAM);

  weight_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .step      (mem_rd_r),
    .advance   (advance_s),
    .mem_addr  (o_mem_addr),
    .node      (node_s),
    .last_word (last_word_s)
  );

`ifdef WEIGHT_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             timeout_s;
  logic             error_r;

  assign timeout_s = (state_r == ST_WAIT_DONE) && !done_bit_s &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts consecutive cycles spent waiting for the done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= TMO_W'(0);
    end else if (state_r == ST_WAIT_DONE) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= TMO_W'(0);
    end
  end

  // Sticky error flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else if (start_s) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end
  end

  assign o_error = error_r;
`else
  assign o_error = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_STREAM;
        else         state_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (last_word_s) state_s = ST_DRAIN;
        else             state_s = ST_STREAM;
      end
      // The final word is on its way while the previous read is still in
      // the pipeline; once rd_d1_r drops, this cycle drives the last enable.
      ST_DRAIN: begin
        if (!rd_d1_r) state_s = ST_WAIT_DONE;
        else          state_s = ST_DRAIN;
      end
      ST_WAIT_DONE: begin
        if (done_bit_s) state_s = ST_NEXT;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
        else if (timeout_s) state_s = ST_IDLE;
`endif
        else state_s = ST_WAIT_DONE;
      end
      ST_NEXT: begin
        if (node_s == NODE_W'(TOTAL_NODE - 1)) state_s = ST_FINISH;
        else                                   state_s = ST_STREAM;
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Registered outputs: read strobe, two-stage weight pipeline, status and node select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_r      <= 1'b0;
      rd_d1_r       <= 1'b0;
      enable_r      <= 1'b0;
      weight_r      <= DATA_WIDTH'(0);
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      weight_addr_r <= TOTAL_NODE'(1);
    end else begin
      mem_rd_r <= (state_s == ST_STREAM);
      rd_d1_r  <= mem_rd_r;
      enable_r <= rd_d1_r;
      if (rd_d1_r) begin
        weight_r <= i_mem_data;
      end
      busy_r <= (state_s == ST_STREAM) || (state_s == ST_DRAIN) ||
                (state_s == ST_WAIT_DONE) || (state_s == ST_NEXT);
      done_r <= (state_s == ST_FINISH);
      if (advance_s) begin
        weight_addr_r <= weight_addr_r << 1;
      end else if ((state_s == ST_IDLE) || (state_s == ST_FINISH)) begin
        weight_addr_r <= TOTAL_NODE'(1);
      end
    end
  end

  assign o_busy               = busy_r;
  assign o_done               = done_r;
  assign o_mem_rd             = mem_rd_r;
  assign o_load_weight_enable = enable_r;
  assign o_weight             = weight_r;
  assign o_weight_addr        = weight_addr_r;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Self-checking bench for weight_stream_loader: a synchronous RAM model, a
// feed_forward responder that pulses done[n] after node n's last word, and a
// reference stream (node, word) built from the network geometry.
module tb_weight_stream_loader;

  localparam int DW    = 32;
  localparam int N_IN  = 2;
  localparam int N_H1  = 5;
  localparam int N_H2  = 5;
  localparam int N_OUT = 3;
  localparam int NODES = N_H1 + N_H2 + N_OUT;
  localparam int WORDS = N_H1 * (N_IN + 1) + N_H2 * (N_H1 + 1) + N_OUT * (N_H2 + 1);
  localparam int AW    = $clog2(WORDS);
  localparam int TMO   = 16;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
  localparam int LONG_WAIT = 8;
`else
  localparam int LONG_WAIT = 48;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             o_busy, o_done, o_error, o_mem_rd;
  logic [AW-1:0]    o_mem_addr;
  logic [DW-1:0]    mem_data = '0;
  logic             o_load_weight_enable;
  logic [NODES-1:0] o_weight_addr;
  logic [DW-1:0]    o_weight;
  logic [NODES-1:0] i_load_weight_done = '0;

  weight_stream_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (i_start),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_error              (o_error),
    .o_mem_rd             (o_mem_rd),
    .o_mem_addr           (o_mem_addr),
    .i_mem_data           (mem_data),
    .o_load_weight_enable (o_load_weight_enable),
    .o_weight_addr        (o_weight_addr),
    .o_weight             (o_weight),
    .i_load_weight_done   (i_load_weight_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram [WORDS];
  always @(posedge clk) begin
    if (o_mem_rd && (o_mem_addr < AW'(WORDS))) mem_data <= ram[o_mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int wpn_ref(input int n);
    if (n < N_H1) return N_IN + 1;
    if (n < N_H1 + N_H2) return N_H1 + 1;
    return N_H2 + 1;
  endfunction

  // Reference model state
  logic [DW-1:0] exp_q[$];
  int            node_q[$];
  int            cnt_node [NODES];
  int            extra_delay [NODES];
  int start_cycle, done_cycle, last_en_cycle, prev_node, n_words, n_done;
  int pend_node, pend_cycle, force_node, force_cycle;
  bit mon_en = 1'b0;
  bit spur_en = 1'b0;

  task automatic init_model();
    int k = 0;
    exp_q.delete();
    node_q.delete();
    for (int n = 0; n < NODES; n++) begin
      for (int j = 0; j < wpn_ref(n); j++) begin
        exp_q.push_back(ram[k]);
        node_q.push_back(n);
        k++;
      end
      cnt_node[n] = 0;
    end
    n_words = 0; n_done = 0; prev_node = 0; pend_node = -1;
    done_cycle = 0; last_en_cycle = 0;
  endtask

  task automatic clear_knobs();
    for (int n = 0; n < NODES; n++) extra_delay[n] = 0;
    spur_en = 1'b0;
    force_node = -1;
  endtask

  // Monitor + done responder: checks every cycle at the falling edge.
  initial begin : monitor
    logic [NODES-1:0] dv, sm;
    logic [DW-1:0]    e;
    int               n;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_eq("sel_onehot", 64'($onehot(o_weight_addr)), 64'd1);
        if (o_load_weight_enable) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            n = node_q.pop_front();
            check_eq("weight", 64'(o_weight), 64'(e));
            check_eq("node_sel", 64'(o_weight_addr), 64'(1) << n);
            if (n_words == 0)        check_eq("start_latency", 64'(cyc - start_cycle), 64'd3);
            else if (n != prev_node) check_eq("done_to_next", 64'(cyc - done_cycle), 64'd4);
            else                     check_eq("burst_gap", 64'(cyc - last_en_cycle), 64'd1);
            n_words++;
            cnt_node[n]++;
            prev_node = n;
            last_en_cycle = cyc;
            if ((node_q.size() == 0 || node_q[0] != n) && extra_delay[n] >= 0) begin
              pend_node  = n;
              pend_cycle = cyc + 2 + extra_delay[n];
            end
          end
        end
        if (o_done) begin
          n_done++;
          check_eq("busy_at_done", 64'(o_busy), 64'd0);
          check_eq("done_latency", 64'(cyc - done_cycle), 64'd2);
        end
      end
      dv = '0;
      if (pend_node >= 0 && cyc == pend_cycle) begin
        dv[pend_node] = 1'b1;
        done_cycle = cyc;
        pend_node = -1;
      end
      if (force_node >= 0 && cyc == force_cycle) begin
        dv[force_node] = 1'b1;
        force_node = -1;
      end
      if (spur_en) begin
        sm = NODES'($urandom) & NODES'($urandom);
        sm[prev_node] = 1'b0;
        if (prev_node + 1 < NODES) sm[prev_node + 1] = 1'b0;
        dv |= sm;
      end
      i_load_weight_done = dv;
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"},   64'(o_busy), 64'd0);
    check_eq({tag, "_done"},   64'(o_done), 64'd0);
    check_eq({tag, "_error"},  64'(o_error), 64'd0);
    check_eq({tag, "_rd"},     64'(o_mem_rd), 64'd0);
    check_eq({tag, "_addr"},   64'(o_mem_addr), 64'd0);
    check_eq({tag, "_en"},     64'(o_load_weight_enable), 64'd0);
    check_eq({tag, "_sel"},    64'(o_weight_addr), 64'd1);
    check_eq({tag, "_weight"}, 64'(o_weight), 64'd0);
  endtask

  // Called on a falling edge; returns on the falling edge after the start pulse.
  task automatic begin_load();
    init_model();
    i_start = 1'b1;
    start_cycle = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_after_start", 64'(o_busy), 64'd1);
    check_eq("first_rd", 64'(o_mem_rd), 64'd1);
    check_eq("first_addr", 64'(o_mem_addr), 64'd0);
  endtask

  task automatic end_load(input string tag);
    for (int i = 0; i < 4000 && n_done == 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check_eq({tag, "_done_count"}, 64'(n_done), 64'd1);
    check_eq({tag, "_words"}, 64'(n_words), 64'(WORDS));
    for (int n = 0; n < NODES; n++) check_eq({tag, "_wpn"}, 64'(cnt_node[n]), 64'(wpn_ref(n)));
    check_eq({tag, "_sel_home"}, 64'(o_weight_addr), 64'd1);
    check_eq({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
  endtask

  task automatic wait_node(input int n);
    for (int i = 0; i < 3000 && !(n_words > 0 && prev_node == n); i++) @(negedge clk);
    check_eq("reach_node", 64'(prev_node), 64'(n));
  endtask

  initial begin : main
    for (int k = 0; k < WORDS; k++) ram[k] = 32'h3F80_0000 + DW'(k);
    clear_knobs();
    init_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Baseline full load
    begin_load();
    end_load("base");

    // Long wait for node 4's done flag
    extra_delay[4] = LONG_WAIT;
    begin_load();
    end_load("delay");
    clear_knobs();

    // Early done[0] during node 0 STREAM and done[7] while on node 2
    begin_load();
    force_node = 0;
    force_cycle = cyc + 1;
    wait_node(2);
    force_node = 7;
    force_cycle = cyc + 2;
    end_load("ignore");

    // Second start while busy
    begin_load();
    wait_node(6);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    end_load("restart");

    // Reset in the middle of node 8, then a clean load
    begin_load();
    wait_node(8);
    mon_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    begin_load();
    end_load("after_rst");

    // Randomised RAM contents, done delays and noise on non-current flags
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < WORDS; k++) ram[k] = $urandom;
      for (int n = 0; n < NODES; n++) extra_delay[n] = int'($urandom_range(5, 0));
      spur_en = 1'b1;
      begin_load();
      end_load("random");
      clear_knobs();
    end

`ifdef WEIGHT_LOADER_TIMEOUT_EN
    // Node 3 never reports done: watchdog aborts the load
    extra_delay[3] = -1;
    begin_load();
    for (int i = 0; i < 1000 && !o_error; i++) @(negedge clk);
    check_eq("tmo_error", 64'(o_error), 64'd1);
    check_eq("tmo_latency", 64'(cyc - last_en_cycle), 64'(TMO + 1));
    check_eq("tmo_busy", 64'(o_busy), 64'd0);
    check_eq("tmo_no_done", 64'(n_done), 64'd0);
    check_eq("tmo_sel", 64'(o_weight_addr), 64'd1);
    repeat (3) @(negedge clk);
    clear_knobs();
    begin_load();
    check_eq("tmo_err_clear", 64'(o_error), 64'd0);
    end_load("tmo_reload");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Synthesizable initiator for the feed_forward weight-load interface.
- Reads all network weights from a synchronous weight RAM and streams them node by node.
- Drives a one-hot node select, a weight word and a per-word enable.
- Advances to the next node only after that node's load-done bit is asserted; signals completion to the DQN top-level controller.

Parameters:
- DATA_WIDTH, 32, weight word width (IEEE-754 single).
- N_IN, 2, network inputs; layer-1 fan-in is N_IN+1 (bias).
- N_H1, 5, layer-1 hidden nodes; layer-2 fan-in is N_H1+1.
- N_H2, 5, layer-2 hidden nodes; output fan-in is N_H2+1.
- N_OUT, 3, output nodes.
- TOTAL_NODE, N_H1+N_H2+N_OUT (13), derived.
- TOTAL_WEIGHT, N_H1*(N_IN+1)+N_H2*(N_H1+1)+N_OUT*(N_H2+1) (63), derived.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request to load all weights.
- o_busy  out  1  high from the cycle after an accepted i_start until o_done.
- o_done  out  1  one-cycle pulse after the last node's done bit is seen.
- o_error  out  1  sticky watchdog error; cleared by i_start.
- o_mem_rd  out  1  RAM read strobe.
- o_mem_addr  out  $clog2(TOTAL_WEIGHT)  RAM word address.
- i_mem_data  in  DATA_WIDTH  RAM read data, valid one cycle after o_mem_rd.
- o_load_weight_enable  out  1  o_weight carries a transfer this cycle.
- o_weight_addr  out  TOTAL_NODE  one-hot current node select.
- o_weight  out  DATA_WIDTH  weight word.
- i_load_weight_done  in  TOTAL_NODE  per-node "all weights received" flags.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_error=0, o_mem_rd=0, o_mem_addr=0, o_load_weight_enable=0, o_weight_addr='d1, o_weight=0.
- Reset mid-operation aborts immediately; no partial state survives.
- Node order: node 0 is bit 0, then layer 1, layer 2, output.
- WPN (words per node): nodes 0..N_H1-1 use N_IN+1; the next N_H2 nodes use N_H1+1; the rest use N_H2+1.
- RAM layout is contiguous: node 0 at 0..2, node 5 at 15..20, node 10 at 45..50, last word at 62.
- FSM IDLE: i_start high -> STREAM; cursor=0, node=0, o_weight_addr=1.
- FSM STREAM: o_mem_rd=1 with o_mem_addr=cursor for WPN consecutive cycles, cursor++ each cycle; after the last read -> DRAIN.
- Pipeline: a read in cycle t gives i_mem_data at t+1, registered onto o_weight/o_load_weight_enable at t+2.
- Start-to-first-enable latency is 3 cycles; enable is high for exactly WPN consecutive cycles per node.
- FSM DRAIN: waits until the node's final enable has been driven (2 cycles) -> WAIT_DONE.
- FSM WAIT_DONE: enable=0. i_load_weight_done[node]=1 -> NEXT. Otherwise hold with no timeout.
- FSM NEXT: if node==TOTAL_NODE-1 -> FINISH. Otherwise o_weight_addr<<=1, node++ -> STREAM; cursor is continuous.
- FSM FINISH: o_done=1 for one cycle, o_busy=0, o_weight_addr='d1 -> IDLE.
- i_start while busy is ignored. Done bits for non-current nodes are ignored.
- A done bit for the current node during STREAM/DRAIN is ignored; only WAIT_DONE samples it.
- o_weight_addr never holds zero and is never multi-hot; it does not wrap past bit TOTAL_NODE-1.

Optional Feature:
- Macro WEIGHT_LOADER_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE. On reaching TIMEOUT_CYCLES without the done bit: set o_error, drop o_busy, skip o_done, return to IDLE with o_weight_addr='d1.
- Not defined: WAIT_DONE waits indefinitely, the counter is absent, o_error is tied 0.

Decomposition:
- Shared package (params.sv): DATA_WIDTH, node counts, TOTAL_NODE, TOTAL_WEIGHT, FSM state enum, and a constant function wpn(node) returning fan-in+1.
- One sub-module, weight_addr_gen: holds node index and cursor, outputs o_mem_addr, WPN and a last-word flag. The FSM stays in the top.

Test Plan:
- RAM word k = 32'h3F800000+k; start pulse; bench asserts done[n] 2 cycles after node n's last word.
  -> 63 enabled words in order; counts 3,3,3,3,3,6×8; o_weight_addr steps 1,2,4..4096; o_done once; o_weight_addr returns to 1.
- Delay done[4] by 50 cycles -> enable stays 0 during the wait, node 5's first read waits for done, total words unchanged.
- Assert done[0] during node 0's STREAM and done[7] while on node 2 -> both ignored, sequence identical to the baseline.
- i_start pulsed again at node 6 -> ignored, single o_done.
- rst_n low while on node 8, then start -> outputs at reset values during reset; full 63-word load from address 0 afterwards.
- With WEIGHT_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16, never assert done[3] -> o_error high 16 cycles after entering WAIT_DONE, o_busy=0, no o_done; a later i_start clears o_error.
